red_pitaya_xadc_drp_ctrl: RTL and testbench
===========================================

Name: red_pitaya_xadc_drp_ctrl

Overview:
- Sequences and arbitrates the single XADC DRP port between two requesters.
- Requester 1, auto-capture: each XADC EOC triggers a read of the converted channel's status register.
- Requester 2, software: one-shot DRP read/write (calibration, config regs 40h-4Fh, alarm limits) from the register bank.
- Sits between the XADC primitive and the AMS register bank; adds timeout, fairness and dropped-sample accounting.

Parameters:
- TIMEOUT_CYC, 64: max cycles from DEN to DRDY before the transaction is aborted.
- MISS_W, 16: width of the saturating dropped-EOC counter.

Ports:
- clk_i  in  1  DRP clock (same clock as XADC DCLK)
- rstn_i  in  1  reset, asynchronous, active-low
- eoc_i  in  1  XADC EOC pulse
- channel_i  in  5  XADC CHANNEL, valid with eoc_i
- sw_req_i  in  1  single-cycle software transaction request
- sw_we_i  in  1  1 = write, 0 = read; sampled with sw_req_i
- sw_addr_i  in  7  DRP address; sampled with sw_req_i
- sw_wdata_i  in  16  write data; sampled with sw_req_i
- sw_busy_o  out  1  SW request pending or in flight
- sw_ack_o  out  1  one-cycle completion pulse
- sw_err_o  out  1  valid with sw_ack_o; 1 = timeout
- sw_rdata_o  out  16  read data; held until next SW ack
- cap_valid_o  out  1  one-cycle pulse, new capture
- cap_addr_o  out  7  address of captured channel
- cap_data_o  out  12  drp_do_i[15:4]
- miss_cnt_o  out  MISS_W  dropped/timed-out captures, saturating
- drp_den_o  out  1  DEN
- drp_dwe_o  out  1  DWE
- drp_daddr_o  out  7  DADDR
- drp_di_o  out  16  DI
- drp_do_i  in  16  DO
- drp_drdy_i  in  1  DRDY

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; pending flags cleared; miss_cnt_o = 0; sw_rdata_o = 0.
- Request latching:
  - eoc_i sets cap_pend and latches cap_ch = channel_i.
  - eoc_i while cap_pend is already set (not yet issued): overwrite cap_ch, miss_cnt_o += 1 (saturate at all-ones).
  - sw_req_i while sw_busy_o = 0: latch we/addr/wdata, set sw_pend; sw_busy_o = 1 from the next cycle until the cycle after sw_ack_o.
  - sw_req_i while sw_busy_o = 1: ignored, no ack.
- All DRP outputs are registered. drp_den_o is high exactly one cycle per transaction. drp_dwe_o and drp_di_o are 0 for captures. drp_daddr_o holds its value until the next issue.
- FSM states: IDLE, CAP_WAIT, SW_WAIT.
  - IDLE: choose cap vs SW per the arbitration rule, issue DEN next cycle, clear the chosen pend flag, enter the matching WAIT state.
  - CAP_WAIT on drdy: next cycle cap_valid_o = 1, cap_addr_o = {2'b00, cap_ch}, cap_data_o = do[15:4]; go to IDLE.
  - SW_WAIT on drdy: next cycle sw_ack_o = 1, sw_err_o = 0, sw_rdata_o = do (reads only; writes leave sw_rdata_o unchanged); go to IDLE.
  - Timeout: cycle counter reset at DEN; reaching TIMEOUT_CYC without drdy returns to IDLE.
    - Capture timeout: miss_cnt_o += 1, no cap_valid_o.
    - SW timeout: sw_ack_o = 1, sw_err_o = 1, sw_rdata_o unchanged.
- Arbitration:
  - Capture has priority by default.
  - A one-bit sw_turn flag is set when a capture completes (drdy or timeout) while sw_pend = 1; when set, SW wins the next IDLE decision, then the flag clears.
  - Bound: a SW request waits at most one capture transaction.
- Latency: eoc_i at cycle n, FSM in IDLE, no competing request → drp_den_o high at n+2; drdy at cycle m → cap_valid_o at m+1. The SW path has identical timing.
- drp_drdy_i while IDLE (stale or post-reset) is ignored.
- eoc_i in the same cycle as a capture drdy: the new request is pended normally; no miss counted.
- Mid-transaction async reset: transaction abandoned, no ack or valid; a late DRDY afterwards is ignored.

Test Plan:
- Single capture: eoc_i with channel_i = 5'd16, drdy 4 cycles after DEN with do = 16'hABC5 → DEN at n+2, daddr = 7'h10, cap_valid_o one cycle, cap_data_o = 12'hABC, miss_cnt_o = 0.
- SW write then read: write addr 7'h41, data 16'h2F0F → DEN with dwe = 1, di = 16'h2F0F, sw_ack_o with sw_err_o = 0; then read addr 7'h41 with do = 16'h2F0F → sw_rdata_o = 16'h2F0F; second sw_req_i while busy produces no extra DEN.
- Fairness: sw_req_i and eoc_i in the same cycle, another eoc_i during CAP_WAIT → order capture, SW, capture; sw_turn clears after the SW transaction.
- Overrun: three eoc_i pulses while a SW transaction is in flight → one capture, of the last channel; miss_cnt_o = 2.
- Timeout: drdy never asserted, TIMEOUT_CYC = 64 → SW gets sw_ack_o with sw_err_o = 1 exactly 64 cycles after DEN; a capture gets miss_cnt_o += 1 and no cap_valid_o; FSM accepts a new request afterwards.
- Reset mid-flight: rstn_i low during SW_WAIT, then drdy after release → all outputs 0 immediately, no ack, stale drdy ignored, next eoc_i processed normally.

Source files
------------

// File: rtl/red_pitaya_xadc_drp_ctrl.sv
// XADC DRP sequencer/arbiter.
// Shares the single XADC DRP port between an EOC-driven auto-capture requester
// and a one-shot software requester. Adds DRDY timeout, SW fairness after a
// capture, and a saturating counter of dropped or timed-out captures.
//
// Ports:
//   clk_i, rstn_i            DRP clock, async active-low reset
//   eoc_i, channel_i         XADC end-of-conversion pulse and channel number
//   sw_req_i/we/addr/wdata   one-cycle SW request and its payload
//   sw_busy_o                SW request pending or in flight
//   sw_ack_o, sw_err_o       SW completion pulse; err = DRDY timeout
//   sw_rdata_o               last SW read data
//   cap_valid_o/addr/data    capture result pulse, channel address, DO[15:4]
//   miss_cnt_o               saturating dropped-capture counter
//   drp_*                    DRP master port towards the XADC primitive
module red_pitaya_xadc_drp_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned MISS_W      = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              eoc_i,
    input  logic [4:0]        channel_i,
    input  logic              sw_req_i,
    input  logic              sw_we_i,
    input  logic [6:0]        sw_addr_i,
    input  logic [15:0]       sw_wdata_i,
    output logic              sw_busy_o,
    output logic              sw_ack_o,
    output logic              sw_err_o,
    output logic [15:0]       sw_rdata_o,
    output logic              cap_valid_o,
    output logic [6:0]        cap_addr_o,
    output logic [11:0]       cap_data_o,
    output logic [MISS_W-1:0] miss_cnt_o,
    output logic              drp_den_o,
    output logic              drp_dwe_o,
    output logic [6:0]        drp_daddr_o,
    output logic [15:0]       drp_di_o,
    input  logic [15:0]       drp_do_i,
    input  logic              drp_drdy_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAP_WAIT = 2'd1,
        SW_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              cap_pend, sw_pend, sw_turn;
    logic [4:0]        cap_ch;
    logic              sw_we_q;
    logic [6:0]        sw_addr_q;
    logic [15:0]       sw_wdata_q;
    logic [CNT_W-1:0]  tmo_cnt;

    logic              issue_cap, issue_sw;
    logic              cap_done, cap_tmo, sw_done, sw_tmo;
    logic              timeout_hit, eoc_overrun, sw_accept;
    logic [1:0]        miss_inc;
    logic [MISS_W:0]   miss_sum;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state, arbitration and completion decode
    always_comb begin
        state_d     = state_q;
        issue_cap   = 1'b0;
        issue_sw    = 1'b0;
        cap_done    = 1'b0;
        cap_tmo     = 1'b0;
        sw_done     = 1'b0;
        sw_tmo      = 1'b0;
        timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
        case (state_q)
            IDLE: begin
                // SW wins only when it was passed over by the previous capture
                if (sw_pend && (sw_turn || !cap_pend)) begin
                    issue_sw = 1'b1;
                    state_d  = SW_WAIT;
                end else if (cap_pend) begin
                    issue_cap = 1'b1;
                    state_d   = CAP_WAIT;
                end
            end
            CAP_WAIT: begin
                if (drp_drdy_i) begin
                    cap_done = 1'b1;
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    cap_tmo = 1'b1;
                    state_d = IDLE;
                end
            end
            SW_WAIT: begin
                if (drp_drdy_i) begin
                    sw_done = 1'b1;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    sw_tmo  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new EOC is only a miss if the older one is not being issued this cycle
    always_comb begin
        eoc_overrun = eoc_i && cap_pend && !issue_cap;
        sw_accept   = sw_req_i && !sw_busy_o;
        miss_inc    = 2'(eoc_overrun) + 2'(cap_tmo);
        miss_sum    = {1'b0, miss_cnt_o} + (MISS_W + 1)'(miss_inc);
    end

    // Request latching and fairness flag
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cap_pend   <= 1'b0;
            cap_ch     <= '0;
            sw_pend    <= 1'b0;
            sw_turn    <= 1'b0;
            sw_busy_o  <= 1'b0;
            sw_we_q    <= 1'b0;
            sw_addr_q  <= '0;
            sw_wdata_q <= '0;
        end else begin
            if (eoc_i) begin
                cap_pend <= 1'b1;
                cap_ch   <= channel_i;
            end else if (issue_cap) begin
                cap_pend <= 1'b0;
            end

            if (sw_accept) begin
                sw_pend    <= 1'b1;
                sw_busy_o  <= 1'b1;
                sw_we_q    <= sw_we_i;
                sw_addr_q  <= sw_addr_i;
                sw_wdata_q <= sw_wdata_i;
            end else begin
                if (issue_sw) sw_pend   <= 1'b0;
                if (sw_ack_o) sw_busy_o <= 1'b0;
            end

            if (issue_sw)                            sw_turn <= 1'b0;
            else if ((cap_done || cap_tmo) && sw_pend) sw_turn <= 1'b1;
        end
    end

    // DRP master outputs; address and data hold until the next issue
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            drp_den_o   <= 1'b0;
            drp_dwe_o   <= 1'b0;
            drp_daddr_o <= '0;
            drp_di_o    <= '0;
            tmo_cnt     <= '0;
        end else begin
            drp_den_o <= issue_cap || issue_sw;
            drp_dwe_o <= issue_sw && sw_we_q;
            if (issue_cap) begin
                drp_daddr_o <= {2'b00, cap_ch};
                drp_di_o    <= '0;
            end else if (issue_sw) begin
                drp_daddr_o <= sw_addr_q;
                drp_di_o    <= sw_we_q ? sw_wdata_q : 16'h0000;
            end
            if (issue_cap || issue_sw) tmo_cnt <= '0;
            else if (state_q != IDLE)  tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // Completion results towards the register bank
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cap_valid_o <= 1'b0;
            cap_addr_o  <= '0;
            cap_data_o  <= '0;
            sw_ack_o    <= 1'b0;
            sw_err_o    <= 1'b0;
            sw_rdata_o  <= '0;
            miss_cnt_o  <= '0;
        end else begin
            cap_valid_o <= cap_done;
            if (cap_done) begin
                cap_addr_o <= drp_daddr_o;
                cap_data_o <= drp_do_i[15:4];
            end
            sw_ack_o <= sw_done || sw_tmo;
            sw_err_o <= sw_tmo;
            if (sw_done && !sw_we_q) sw_rdata_o <= drp_do_i;
            miss_cnt_o <= miss_sum[MISS_W] ? {MISS_W{1'b1}} : miss_sum[MISS_W-1:0];
        end
    end

endmodule

// File: tb/tb_red_pitaya_xadc_drp_ctrl.sv
// Self-checking bench for red_pitaya_xadc_drp_ctrl: a transaction-level model
// predicts every output each cycle, a DRP responder answers DEN after a
// programmable delay, and directed tests pin key values with literals.
module tb_red_pitaya_xadc_drp_ctrl;

    localparam int TMO      = 64;
    localparam int MISS_W   = 16;
    localparam int MISS_MAX = (1 << MISS_W) - 1;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              eoc_i;
    logic [4:0]        channel_i;
    logic              sw_req_i, sw_we_i;
    logic [6:0]        sw_addr_i;
    logic [15:0]       sw_wdata_i;
    logic              sw_busy_o, sw_ack_o, sw_err_o;
    logic [15:0]       sw_rdata_o;
    logic              cap_valid_o;
    logic [6:0]        cap_addr_o;
    logic [11:0]       cap_data_o;
    logic [MISS_W-1:0] miss_cnt_o;
    logic              drp_den_o, drp_dwe_o;
    logic [6:0]        drp_daddr_o;
    logic [15:0]       drp_di_o;
    logic [15:0]       drp_do_i;
    logic              drp_drdy_i;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    red_pitaya_xadc_drp_ctrl #(.TIMEOUT_CYC(TMO), .MISS_W(MISS_W)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .eoc_i(eoc_i), .channel_i(channel_i),
        .sw_req_i(sw_req_i), .sw_we_i(sw_we_i), .sw_addr_i(sw_addr_i), .sw_wdata_i(sw_wdata_i),
        .sw_busy_o(sw_busy_o), .sw_ack_o(sw_ack_o), .sw_err_o(sw_err_o), .sw_rdata_o(sw_rdata_o),
        .cap_valid_o(cap_valid_o), .cap_addr_o(cap_addr_o), .cap_data_o(cap_data_o),
        .miss_cnt_o(miss_cnt_o), .drp_den_o(drp_den_o), .drp_dwe_o(drp_dwe_o),
        .drp_daddr_o(drp_daddr_o), .drp_di_o(drp_di_o), .drp_do_i(drp_do_i), .drp_drdy_i(drp_drdy_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- DRP responder ----------------
    int          resp_delay = 0;   // cycles from DEN to DRDY, <=0 means never
    logic [15:0] resp_data  = '0;
    int          rcnt       = 0;
    initial begin
        drp_drdy_i = 1'b0;
        drp_do_i   = '0;
        forever begin
            @(negedge clk_i);
            drp_drdy_i = 1'b0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    drp_drdy_i = 1'b1;
                    drp_do_i   = resp_data;
                end
            end
            if (drp_den_o === 1'b1 && resp_delay > 0) rcnt = resp_delay;
        end
    end

    // ---------------- transaction-level model ----------------
    // m_kind: 0 = nothing outstanding, 1 = capture outstanding, 2 = SW outstanding
    int          m_cyc, m_den_cyc, m_kind, m_miss;
    bit          m_cap_pend, m_sw_pend, m_turn, m_busy, m_sw_we, m_ack_prev, m_ok, m_to;
    logic [4:0]  m_cap_ch;
    logic [6:0]  m_sw_addr;
    logic [15:0] m_sw_wdata;
    bit          e_den, e_dwe, e_cv, e_ack, e_err;
    logic [6:0]  e_daddr, e_caddr;
    logic [15:0] e_di, e_rdata;
    logic [11:0] e_cdata;

    initial begin
        forever begin
            @(posedge clk_i or negedge rstn_i);
            if (!rstn_i) begin
                m_cyc = 0; m_den_cyc = 0; m_kind = 0; m_miss = 0;
                m_cap_pend = 0; m_sw_pend = 0; m_turn = 0; m_busy = 0; m_sw_we = 0;
                m_cap_ch = '0; m_sw_addr = '0; m_sw_wdata = '0;
                e_den = 0; e_dwe = 0; e_cv = 0; e_ack = 0; e_err = 0;
                e_daddr = '0; e_caddr = '0; e_di = '0; e_rdata = '0; e_cdata = '0;
            end else begin
                m_ack_prev = e_ack;
                m_cyc++;
                e_den = 0; e_dwe = 0; e_cv = 0; e_ack = 0; e_err = 0;
                if (m_kind != 0) begin
                    m_ok = drp_drdy_i;
                    m_to = !drp_drdy_i && (m_cyc - m_den_cyc == TMO - 1);
                    if (m_ok || m_to) begin
                        if (m_kind == 1) begin
                            if (m_ok) begin
                                e_cv = 1; e_caddr = e_daddr; e_cdata = drp_do_i[15:4];
                            end else m_miss++;
                            if (m_sw_pend) m_turn = 1;
                        end else begin
                            e_ack = 1; e_err = m_to;
                            if (m_ok && !m_sw_we) e_rdata = drp_do_i;
                        end
                        m_kind = 0;
                    end
                end else if (m_cap_pend || m_sw_pend) begin
                    e_den = 1; m_den_cyc = m_cyc + 1;
                    if (m_sw_pend && (m_turn || !m_cap_pend)) begin
                        m_kind = 2; m_sw_pend = 0; m_turn = 0;
                        e_dwe = m_sw_we; e_daddr = m_sw_addr;
                        e_di = m_sw_we ? m_sw_wdata : 16'h0000;
                    end else begin
                        m_kind = 1; m_cap_pend = 0;
                        e_daddr = {2'b00, m_cap_ch}; e_di = '0;
                    end
                end
                if (eoc_i) begin
                    if (m_cap_pend) m_miss++;
                    m_cap_pend = 1; m_cap_ch = channel_i;
                end
                if (m_busy && m_ack_prev) m_busy = 0;
                else if (!m_busy && sw_req_i) begin
                    m_busy = 1; m_sw_pend = 1;
                    m_sw_we = sw_we_i; m_sw_addr = sw_addr_i; m_sw_wdata = sw_wdata_i;
                end
                if (m_miss > MISS_MAX) m_miss = MISS_MAX;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            if (chk_en) begin
                chk("den",   32'(drp_den_o),   32'(e_den));
                chk("dwe",   32'(drp_dwe_o),   32'(e_dwe));
                chk("busy",  32'(sw_busy_o),   32'(m_busy));
                chk("cv",    32'(cap_valid_o), 32'(e_cv));
                chk("ack",   32'(sw_ack_o),    32'(e_ack));
                chk("miss",  32'(miss_cnt_o),  32'(m_miss));
                chk("rdata", 32'(sw_rdata_o),  32'(e_rdata));
                if (e_den) begin
                    chk("daddr", 32'(drp_daddr_o), 32'(e_daddr));
                    chk("di",    32'(drp_di_o),    32'(e_di));
                end
                if (e_cv) begin
                    chk("caddr", 32'(cap_addr_o), 32'(e_caddr));
                    chk("cdata", 32'(cap_data_o), 32'(e_cdata));
                end
                if (e_ack) chk("err", 32'(sw_err_o), 32'(e_err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic pulse_eoc(input logic [4:0] ch);
        @(negedge clk_i); eoc_i = 1'b1; channel_i = ch;
        @(negedge clk_i); eoc_i = 1'b0;
    endtask

    task automatic pulse_sw(input logic we, input logic [6:0] a, input logic [15:0] d);
        @(negedge clk_i); sw_req_i = 1'b1; sw_we_i = we; sw_addr_i = a; sw_wdata_i = d;
        @(negedge clk_i); sw_req_i = 1'b0;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return drp_den_o;
            1:       return cap_valid_o;
            default: return sw_ack_o;
        endcase
    endfunction

    task automatic wait_for(input int which, input string nm, output int n);
        logic hit;
        n = 0; hit = 1'b0;
        while (!hit && n < 200) begin
            @(negedge clk_i);
            n++;
            hit = sel(which);
        end
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL %s got no event want event within %0d cycles", nm, n);
        end
    endtask

    task automatic count_ev(input int which, input int cyc, output int c);
        c = 0;
        repeat (cyc) begin
            @(negedge clk_i);
            if (sel(which) === 1'b1) c++;
        end
    endtask

    // ---------------- directed tests ----------------
    int n, c;
    initial begin
        rstn_i = 1'b1; eoc_i = 1'b0; channel_i = '0;
        sw_req_i = 1'b0; sw_we_i = 1'b0; sw_addr_i = '0; sw_wdata_i = '0;
        #2 rstn_i = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_den",  32'(drp_den_o),  32'h0);
        chk("rst_busy", 32'(sw_busy_o),  32'h0);
        chk("rst_miss", 32'(miss_cnt_o), 32'h0);
        tick(2);
        #2 rstn_i = 1'b1;
        tick(2);

        // single capture
        resp_delay = 4; resp_data = 16'hABC5;
        pulse_eoc(5'd16);
        wait_for(0, "t1_den", n);
        chk("t1_den_lat",  32'(n + 1), 32'd2);
        chk("t1_daddr",    32'(drp_daddr_o), 32'h10);
        chk("t1_dwe",      32'(drp_dwe_o),   32'h0);
        wait_for(1, "t1_cv", n);
        chk("t1_cv_lat",   32'(n), 32'd5);
        chk("t1_cdata",    32'(cap_data_o), 32'hABC);
        chk("t1_caddr",    32'(cap_addr_o), 32'h10);
        chk("t1_miss",     32'(miss_cnt_o), 32'h0);

        // eoc in the same cycle as capture drdy: pended, no miss
        resp_delay = 3; resp_data = 16'h1115;
        pulse_eoc(5'd2);
        wait_for(0, "t1b_den", n);
        tick(2);
        pulse_eoc(5'd3);
        wait_for(0, "t1b_den2", n);
        chk("t1b_daddr", 32'(drp_daddr_o), 32'h03);
        chk("t1b_miss",  32'(miss_cnt_o),  32'h0);
        wait_for(1, "t1b_cv", n);
        tick(3);

        // SW write, ignored request while busy, then read back
        resp_delay = 4; resp_data = 16'h2F0F;
        pulse_sw(1'b1, 7'h41, 16'h2F0F);
        wait_for(0, "t2_den", n);
        chk("t2_dwe",   32'(drp_dwe_o),   32'h1);
        chk("t2_di",    32'(drp_di_o),    32'h2F0F);
        chk("t2_daddr", 32'(drp_daddr_o), 32'h41);
        pulse_sw(1'b0, 7'h00, 16'h0000);
        wait_for(2, "t2_ack", n);
        chk("t2_err", 32'(sw_err_o), 32'h0);
        count_ev(0, 10, c);
        chk("t2_no_extra_den", 32'(c), 32'h0);
        chk("t2_idle_busy",    32'(sw_busy_o), 32'h0);
        pulse_sw(1'b0, 7'h41, 16'h0000);
        wait_for(2, "t2_rd_ack", n);
        chk("t2_rdata", 32'(sw_rdata_o), 32'h2F0F);
        chk("t2_rd_err", 32'(sw_err_o), 32'h0);
        tick(3);

        // fairness: capture, SW, capture
        @(negedge clk_i);
        eoc_i = 1'b1; channel_i = 5'd3;
        sw_req_i = 1'b1; sw_we_i = 1'b0; sw_addr_i = 7'h42; sw_wdata_i = '0;
        @(negedge clk_i); eoc_i = 1'b0; sw_req_i = 1'b0;
        wait_for(0, "t3_den1", n);
        chk("t3_first", 32'(drp_daddr_o), 32'h03);
        pulse_eoc(5'd5);
        wait_for(0, "t3_den2", n);
        chk("t3_second", 32'(drp_daddr_o), 32'h42);
        wait_for(0, "t3_den3", n);
        chk("t3_third", 32'(drp_daddr_o), 32'h05);
        wait_for(1, "t3_cv", n);
        tick(5);
        // sw_turn must be clear again: capture wins a fresh tie
        @(negedge clk_i);
        eoc_i = 1'b1; channel_i = 5'd6;
        sw_req_i = 1'b1; sw_we_i = 1'b0; sw_addr_i = 7'h44;
        @(negedge clk_i); eoc_i = 1'b0; sw_req_i = 1'b0;
        wait_for(0, "t3_den4", n);
        chk("t3_turn_clear", 32'(drp_daddr_o), 32'h06);
        wait_for(2, "t3_ack", n);
        tick(3);

        // overrun: three EOCs while SW is in flight
        resp_delay = 20;
        pulse_sw(1'b1, 7'h48, 16'h0001);
        wait_for(0, "t4_den", n);
        pulse_eoc(5'd1);
        pulse_eoc(5'd2);
        pulse_eoc(5'd7);
        chk("t4_miss_mid", 32'(miss_cnt_o), 32'd2);
        wait_for(2, "t4_ack", n);
        wait_for(0, "t4_cap_den", n);
        chk("t4_daddr", 32'(drp_daddr_o), 32'h07);
        wait_for(1, "t4_cv", n);
        count_ev(0, 10, c);
        chk("t4_one_cap", 32'(c), 32'h0);
        chk("t4_miss",    32'(miss_cnt_o), 32'd2);

        // timeouts
        resp_delay = -1;
        pulse_sw(1'b0, 7'h40, 16'h0000);
        wait_for(0, "t5_den", n);
        wait_for(2, "t5_ack", n);
        chk("t5_tmo_lat", 32'(n), 32'd64);
        chk("t5_err",     32'(sw_err_o),   32'h1);
        chk("t5_rdata",   32'(sw_rdata_o), 32'h2F0F);
        pulse_eoc(5'd9);
        count_ev(1, 80, c);
        chk("t5_no_cv", 32'(c), 32'h0);
        chk("t5_miss",  32'(miss_cnt_o), 32'd3);
        resp_delay = 2; resp_data = 16'h1230;
        pulse_eoc(5'd17);
        wait_for(1, "t5_cv", n);
        chk("t5_cdata", 32'(cap_data_o), 32'h123);
        chk("t5_caddr", 32'(cap_addr_o), 32'h11);
        tick(3);

        // reset in SW_WAIT, late DRDY afterwards
        resp_delay = 10; resp_data = 16'hDEAD;
        pulse_sw(1'b0, 7'h43, 16'h0000);
        wait_for(0, "t6_den", n);
        tick(2);
        #2 rstn_i = 1'b0;
        #1;
        chk("t6_busy",  32'(sw_busy_o),   32'h0);
        chk("t6_daddr", 32'(drp_daddr_o), 32'h0);
        chk("t6_miss",  32'(miss_cnt_o),  32'h0);
        chk("t6_rdata", 32'(sw_rdata_o),  32'h0);
        tick(2);
        #2 rstn_i = 1'b1;
        count_ev(2, 12, c);
        chk("t6_no_ack", 32'(c), 32'h0);
        resp_delay = 3; resp_data = 16'h5550;
        pulse_eoc(5'd4);
        wait_for(1, "t6_cv", n);
        chk("t6_cdata", 32'(cap_data_o), 32'h555);
        chk("t6_caddr", 32'(cap_addr_o), 32'h04);
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
